// File: rtl/shapool_pkg.sv
// Shared types and constants for the shapool job sequencer and its nonce fixup.
package shapool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int FLUSH_CYCLES = 2;
  localparam int ROUNDS       = 64;
  localparam int PIPE_DELAY   = 2;

endpackage

// File: rtl/shapool_nonce_fixup.sv
// Recovers the hashed nonce from the pool's live nonce: undo the pipeline advance,
// re-apply the MSB seed and prepend the index of the lowest matching pipeline.
module shapool_nonce_fixup
  import shapool_pkg::*;
#(
  parameter int POOL_SIZE      = 2,
  parameter int POOL_SIZE_LOG2 = 1
) (
  input  logic [31:0] i_pool_nonce,
  input  logic [7:0]  i_match_flags,
  input  logic [7:0]  i_nonce_start_msb,
  output logic [31:0] o_nonce
);

  localparam int NLW = 32 - POOL_SIZE_LOG2;

  logic [NLW-1:0]            w_lower;
  logic [POOL_SIZE_LOG2-1:0] w_idx;
  logic                      w_unused;

  assign w_lower = i_pool_nonce[NLW-1:0] - NLW'(PIPE_DELAY);

  // Scan from the top so the lowest set flag is the one left standing.
  always_comb begin
    w_idx = '0;
    for (int i = POOL_SIZE - 1; i >= 0; i--) begin
      if (i_match_flags[i]) w_idx = POOL_SIZE_LOG2'(i);
    end
  end

  assign o_nonce  = {w_idx, w_lower[NLW-1:NLW-8] ^ i_nonce_start_msb, w_lower[NLW-9:0]};
  assign w_unused = ^{i_pool_nonce >> NLW, i_match_flags >> POOL_SIZE};

endmodule

// File: rtl/shapool_job_sequencer.sv
// Job-level controller for shapool: job intake, pool reset sequencing, round
// tracking, result capture. Optional abort input under SHAPOOL_JOB_SEQUENCER_ABORT_EN.
// Handshakes: a transfer happens on a clock edge where valid and ready are both high;
// job_ready is high only in IDLE, result_valid only in DONE, and DONE holds its
// fields until the edge that sees result_ready.
module shapool_job_sequencer
  import shapool_pkg::*;
#(
  parameter int POOL_SIZE      = 2,
  parameter int POOL_SIZE_LOG2 = 1,
  parameter int SEARCH_LOG2    = 32 - POOL_SIZE_LOG2
) (
  input  logic         clk,
  input  logic         reset_n,
`ifdef SHAPOOL_JOB_SEQUENCER_ABORT_EN
  input  logic         abort,
`endif
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_sha_state,
  input  logic [95:0]  job_message_head,
  input  logic [7:0]   job_nonce_start_MSB,
  output logic         pool_reset_n,
  output logic [255:0] pool_sha_state,
  output logic [95:0]  pool_message_head,
  output logic [7:0]   pool_nonce_start_MSB,
  input  logic         pool_success,
  input  logic [31:0]  pool_nonce,
  input  logic [7:0]   pool_match_flags,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         result_found,
  output logic [31:0]  result_nonce,
  output logic [7:0]   result_match_flags,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam int TW = SEARCH_LOG2 + 7;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  // Last checked nonce k = 2^SEARCH_LOG2-1 lands at t = ROUNDS*PIPE_DELAY + ROUNDS*k.
  localparam logic [TW-1:0] T_LAST =
    TW'((64'(ROUNDS) << SEARCH_LOG2) + 64'(ROUNDS * PIPE_DELAY) - 64'(ROUNDS));

  state_t         r_state;
  state_t         w_next;
  logic [FW-1:0]  r_flush_cnt;
  logic [TW-1:0]  r_t;
  logic           w_hit;
  logic           w_miss;
  logic           w_abort;
  logic [31:0]    w_fixed_nonce;

  logic [255:0]   r_sha_state;
  logic [95:0]    r_message_head;
  logic [7:0]     r_nonce_start_msb;
  logic           r_found;
  logic [31:0]    r_nonce;
  logic [7:0]     r_flags;

`ifdef SHAPOOL_JOB_SEQUENCER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  shapool_nonce_fixup #(
    .POOL_SIZE      (POOL_SIZE),
    .POOL_SIZE_LOG2 (POOL_SIZE_LOG2)
  ) u_fixup (
    .i_pool_nonce      (pool_nonce),
    .i_match_flags     (pool_match_flags),
    .i_nonce_start_msb (r_nonce_start_msb),
    .o_nonce           (w_fixed_nonce)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_hit  = 1'b0;
    w_miss = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (job_valid) w_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (w_abort) begin
          w_next = ST_DONE;
          w_miss = 1'b1;
        end else if (r_flush_cnt == FW'(FLUSH_CYCLES - 1)) begin
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // Success outranks both abort and exhaustion in the same cycle.
        if (pool_success) begin
          w_next = ST_DONE;
          w_hit  = 1'b1;
        end else if (w_abort || r_t == T_LAST) begin
          w_next = ST_DONE;
          w_miss = 1'b1;
        end
      end
      ST_DONE: begin
        if (result_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flush_cnt       <= '0;
      r_t               <= '0;
      r_sha_state       <= '0;
      r_message_head    <= '0;
      r_nonce_start_msb <= '0;
      r_found           <= 1'b0;
      r_nonce           <= '0;
      r_flags           <= '0;
    end else begin
      if (r_state == ST_IDLE && job_valid) begin
        r_sha_state       <= job_sha_state;
        r_message_head    <= job_message_head;
        r_nonce_start_msb <= job_nonce_start_MSB;
      end

      if (r_state == ST_FLUSH) r_flush_cnt <= r_flush_cnt + FW'(1);
      else                     r_flush_cnt <= '0;

      // t is 0 on the first RUN cycle, tracking the pool's round counter.
      if (r_state == ST_RUN) r_t <= r_t + TW'(1);
      else                   r_t <= '0;

      if (w_hit) begin
        r_found <= 1'b1;
        r_nonce <= w_fixed_nonce;
        r_flags <= pool_match_flags;
      end else if (w_miss) begin
        r_found <= 1'b0;
        r_nonce <= '0;
        r_flags <= '0;
      end
    end
  end

  assign job_ready            = (r_state == ST_IDLE);
  assign pool_reset_n         = (r_state == ST_RUN);
  assign busy                 = (r_state == ST_FLUSH) || (r_state == ST_RUN);
  assign result_valid         = (r_state == ST_DONE);
  assign result_found         = r_found;
  assign result_nonce         = r_nonce;
  assign result_match_flags   = r_flags;
  assign pool_sha_state       = r_sha_state;
  assign pool_message_head    = r_message_head;
  assign pool_nonce_start_MSB = r_nonce_start_msb;
  assign dbg_state            = r_state;

endmodule

// File: tb/tb_shapool_job_sequencer.sv
// Scoreboard bench for shapool_job_sequencer: driver plays the pool, a monitor
// compares each presented result against a queue of model-predicted results.
module tb_shapool_job_sequencer;

  localparam int PSL         = 1;
  localparam int PS          = 1 << PSL;
  localparam int SEARCH_LOG2 = 2;
  localparam int T_LAST      = 64 * 2 + 64 * ((1 << SEARCH_LOG2) - 1);

  logic         clk;
  logic         reset_n;
  logic         job_valid;
  logic         job_ready;
  logic [255:0] job_sha_state;
  logic [95:0]  job_message_head;
  logic [7:0]   job_nonce_start_MSB;
  logic         pool_reset_n;
  logic [255:0] pool_sha_state;
  logic [95:0]  pool_message_head;
  logic [7:0]   pool_nonce_start_MSB;
  logic         pool_success;
  logic [31:0]  pool_nonce;
  logic [7:0]   pool_match_flags;
  logic         result_valid;
  logic         result_ready;
  logic         result_found;
  logic [31:0]  result_nonce;
  logic [7:0]   result_match_flags;
  logic         busy;
  logic [1:0]   dbg_state;
`ifdef SHAPOOL_JOB_SEQUENCER_ABORT_EN
  logic         abort;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [40:0] exp_q[$];

  shapool_job_sequencer #(
    .POOL_SIZE      (PS),
    .POOL_SIZE_LOG2 (PSL),
    .SEARCH_LOG2    (SEARCH_LOG2)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
`ifdef SHAPOOL_JOB_SEQUENCER_ABORT_EN
    .abort                (abort),
`endif
    .job_valid            (job_valid),
    .job_ready            (job_ready),
    .job_sha_state        (job_sha_state),
    .job_message_head     (job_message_head),
    .job_nonce_start_MSB  (job_nonce_start_MSB),
    .pool_reset_n         (pool_reset_n),
    .pool_sha_state       (pool_sha_state),
    .pool_message_head    (pool_message_head),
    .pool_nonce_start_MSB (pool_nonce_start_MSB),
    .pool_success         (pool_success),
    .pool_nonce           (pool_nonce),
    .pool_match_flags     (pool_match_flags),
    .result_valid         (result_valid),
    .result_ready         (result_ready),
    .result_found         (result_found),
    .result_nonce         (result_nonce),
    .result_match_flags   (result_match_flags),
    .busy                 (busy),
    .dbg_state            (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the pool runs PIPE_DELAY nonces ahead; strip that, re-seed the
  // top 8 bits of the per-pipeline nonce, and put the winning pipeline index on top.
  function automatic logic [31:0] model_nonce(input logic [31:0] nonce, input logic [7:0] flags,
                                               input logic [7:0] msb);
    longint unsigned span     = 64'd1 << (32 - PSL);
    longint unsigned low_span = 64'd1 << (32 - PSL - 8);
    longint unsigned lower    = ((64'(nonce) % span) + span - 2) % span;
    longint unsigned top8     = (lower / low_span) ^ 64'(msb);
    int idx = 0;
    for (int b = PS - 1; b >= 0; b--) if (flags[b]) idx = b;
    return 32'(64'(idx) * span + top8 * low_span + lower % low_span);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: one comparison set per result presentation
  initial begin
    logic prev_valid;
    logic [40:0] e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && result_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL result_unexpected: got nonce %0h with no expected entry", result_nonce);
        end else begin
          e = exp_q.pop_front();
          check("result_found", result_found, e[40]);
          check("result_nonce", result_nonce, e[39:8]);
          check("result_match_flags", result_match_flags, e[7:0]);
        end
      end
      prev_valid = result_valid;
    end
  end

  // Driver tasks
  task automatic send_job(input logic [7:0] msb, input logic [255:0] sha, input logic [95:0] head);
    int guard = 0;
    @(negedge clk);
    while (!job_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!job_ready) begin
      check("job_ready_timeout", job_ready, 1);
      reset_n = 1'b0;
      #2 reset_n = 1'b1;
      @(negedge clk);
    end
    job_valid           = 1'b1;
    job_sha_state       = sha;
    job_message_head    = head;
    job_nonce_start_MSB = msb;
    @(posedge clk);
    #1;
    job_valid           = 1'b0;
    job_sha_state       = rand256();
    job_message_head    = {$urandom, $urandom, $urandom};
    job_nonce_start_MSB = 8'($urandom);
  endtask

  task automatic run_job(input logic [7:0] msb, input int succ_t, input logic [31:0] nonce,
                         input logic [7:0] flags, input int hold, input int abort_t);
    logic [255:0] sha;
    logic [95:0]  head;
    logic [40:0]  e;
    int end_t;
    logic found;
    sha   = rand256();
    head  = {$urandom, $urandom, $urandom};
    end_t = T_LAST;
    if (succ_t >= 0 && succ_t < end_t) end_t = succ_t;
    if (abort_t >= 0 && abort_t < end_t) end_t = abort_t;
    found = (succ_t >= 0 && succ_t <= end_t);
    e = found ? {1'b1, model_nonce(nonce, flags, msb), flags} : 41'd0;
    exp_q.push_back(e);

    send_job(msb, sha, head);
    // FLUSH: pool success is junk here and must be ignored
    pool_success     = 1'b1;
    pool_nonce       = $urandom;
    pool_match_flags = 8'hff;
    @(negedge clk);
    check("flush_busy", busy, 1);
    check("flush_pool_reset_n", pool_reset_n, 0);
    check("flush_job_ready", job_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("flush2_pool_reset_n", pool_reset_n, 0);
    @(posedge clk);
    #1;

    for (int t = 0; t <= end_t; t++) begin
      if (t == succ_t) begin
        pool_success     = 1'b1;
        pool_nonce       = nonce;
        pool_match_flags = flags;
      end else begin
        pool_success     = 1'b0;
        pool_nonce       = $urandom;
        pool_match_flags = 8'($urandom);
      end
`ifdef SHAPOOL_JOB_SEQUENCER_ABORT_EN
      abort = (t == abort_t);
`endif
      if (t == 0 || t == end_t) begin
        @(negedge clk);
        if (t == 0) check("run_pool_reset_n", pool_reset_n, 1);
        if (t == end_t) check("pre_result_valid", result_valid, 0);
      end
      @(posedge clk);
      #1;
    end
    pool_success = 1'b0;
`ifdef SHAPOOL_JOB_SEQUENCER_ABORT_EN
    abort = 1'b0;
`endif
    check("result_valid_latency", result_valid, 1);
    check("done_pool_reset_n", pool_reset_n, 0);
    check("param_sha", pool_sha_state, sha);
    check("param_head", pool_message_head, head);
    check("param_msb", pool_nonce_start_MSB, msb);

    // DONE hold: noise on job_valid and pool_success must change nothing
    job_valid    = 1'b1;
    pool_success = 1'b1;
    for (int i = 0; i < hold; i++) begin
      pool_nonce = $urandom;
      @(negedge clk);
      check("hold_valid", result_valid, 1);
      check("hold_job_ready", job_ready, 0);
      check("hold_nonce", result_nonce, e[39:8]);
      check("hold_found", result_found, e[40]);
    end
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    job_valid    = 1'b0;
    result_ready = 1'b0;
    pool_success = 1'b0;
    check("release_job_ready", job_ready, 1);
    check("release_result_valid", result_valid, 0);
  endtask

  task automatic reset_mid_run(input int at_t);
    send_job(8'h3c, rand256(), {$urandom, $urandom, $urandom});
    repeat (2) @(posedge clk);
    #1;
    for (int t = 0; t < at_t; t++) begin
      @(posedge clk);
      #1;
    end
    #2 reset_n = 1'b0;
    #1;
    check("areset_job_ready", job_ready, 1);
    check("areset_pool_reset_n", pool_reset_n, 0);
    check("areset_busy", busy, 0);
    check("areset_result_valid", result_valid, 0);
    check("areset_pool_sha", pool_sha_state, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Main sequence
  initial begin
    reset_n             = 1'b0;
    job_valid           = 1'b0;
    job_sha_state       = '0;
    job_message_head    = '0;
    job_nonce_start_MSB = '0;
    pool_success        = 1'b0;
    pool_nonce          = '0;
    pool_match_flags    = '0;
    result_ready        = 1'b0;
`ifdef SHAPOOL_JOB_SEQUENCER_ABORT_EN
    abort               = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_job_ready", job_ready, 1);
    check("reset_pool_reset_n", pool_reset_n, 0);
    check("reset_result_valid", result_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_result_found", result_found, 0);
    check("reset_result_nonce", result_nonce, 0);
    check("reset_result_flags", result_match_flags, 0);
    check("reset_pool_msb", pool_nonce_start_MSB, 0);

    run_job(8'h00, 192, 32'h0000_0005, 8'h02, 10, -1);
    run_job(8'ha5, 192, 32'h0000_0005, 8'h02, 1, -1);
    run_job(8'ha5, 192, 32'h0000_0005, 8'h03, 1, -1);
    run_job(8'h5a, 1, 32'h0000_0001, 8'h01, 0, -1);
    run_job(8'h11, -1, 32'h0, 8'h0, 2, -1);
    run_job(8'h22, T_LAST, 32'hffff_ffff, 8'h02, 2, -1);
    reset_mid_run(100);
`ifdef SHAPOOL_JOB_SEQUENCER_ABORT_EN
    run_job(8'h77, -1, 32'h0, 8'h0, 1, 50);
    run_job(8'h77, 60, 32'h1234_5678, 8'h02, 1, 60);
`endif

    for (int j = 0; j < 12; j++) begin
      logic [7:0] f;
      int st;
      f = 8'($urandom_range(0, 255));
      if (f[PS-1:0] == '0) f[0] = 1'b1;
      st = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, T_LAST));
      run_job(8'($urandom), st, $urandom, f, int'($urandom_range(0, 4)), -1);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
